// File: rtl/vram_arbiter_pkg.sv
// Shared geometry, widths and encodings for the frame-buffer arbiter.
package vram_arbiter_pkg;

    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned SHIFT    = 2;
    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned PIX_W    = 10;
    localparam int unsigned FB_WORDS = FB_W * FB_H;

    // FB_W = 2**7 + 2**5, so a row offset is two shifts and an add
    localparam int unsigned FB_W_SH_HI = 7;
    localparam int unsigned FB_W_SH_LO = 5;

    typedef enum logic [1:0] {
        SLOT_FETCH   = 2'd0,
        SLOT_CAPTURE = 2'd1,
        SLOT_SPARE   = 2'd2,
        SLOT_LAST    = 2'd3
    } slot_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_ACK  = 1'b1
    } wr_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Pixel-writer request/acknowledge channel into the frame-buffer arbiter.
interface vram_arbiter_if;
    import vram_arbiter_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ack_c;
    logic              err;

    modport master (output req, addr, data, input  ack_c, err);
    modport slave  (input  req, addr, data, output ack_c, err);

endinterface

// File: rtl/vram_addr_gen.sv
// Maps a 640x480 display coordinate onto the 160x120 frame-buffer word address.
module vram_addr_gen
    import vram_arbiter_pkg::*;
(
    input  logic [PIX_W-1:0]  pixel_x_i,
    input  logic [PIX_W-1:0]  pixel_y_i,
    output logic [ADDR_W-1:0] fb_addr_c_o
);

    logic [ADDR_W-1:0] fx;
    logic [ADDR_W-1:0] fy;

    assign fx = ADDR_W'(pixel_x_i >> SHIFT);
    assign fy = ADDR_W'(pixel_y_i >> SHIFT);

    assign fb_addr_c_o = (fy << FB_W_SH_HI) + (fy << FB_W_SH_LO) + fx;

endmodule

// File: rtl/vram_arbiter.sv
// Time-slices a single-port frame-buffer RAM between display scan-out (slot 0)
// and one pixel writer, and drives the registered rgb/sync outputs.
module vram_arbiter
    import vram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              p_tick_i,
    input  logic              video_on_i,
    input  logic [PIX_W-1:0]  pixel_x_i,
    input  logic [PIX_W-1:0]  pixel_y_i,
    input  logic              hsync_i,
    input  logic              vsync_i,
    vram_arbiter_if.slave     wr,
    output logic              mem_en_c_o,
    output logic              mem_we_c_o,
    output logic [ADDR_W-1:0] mem_addr_c_o,
    output logic [DATA_W-1:0] mem_wdata_c_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [DATA_W-1:0] rgb_o
);

    slot_e             slot_q, slot_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic              wr_err_q, wr_err_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] pix_buf_q;
    logic [DATA_W-1:0] rgb_q;
    logic              video_on_q;
    logic              hsync_q;
    logic              vsync_q;
    logic [ADDR_W-1:0] fb_addr;
    logic              fetch;
    logic              in_range;
    logic              ack_c;

    vram_addr_gen u_addr_gen (
        .pixel_x_i   (pixel_x_i),
        .pixel_y_i   (pixel_y_i),
        .fb_addr_c_o (fb_addr)
    );

    assign fetch    = (slot_q == SLOT_FETCH) && video_on_i;
    assign in_range = wr.addr < ADDR_W'(FB_WORDS);

    // Slot counter restarts on p_tick and parks in the last slot if ticks stop.
    always_comb begin
        slot_d = slot_q;
        if (p_tick_i) begin
            slot_d = SLOT_FETCH;
        end else if (slot_q != SLOT_LAST) begin
            slot_d = slot_e'(slot_q + 2'd1);
        end
    end

    // Writer FSM and RAM port mux; address/data hold their last value when idle.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_err_d      = wr_err_q;
        ack_c         = 1'b0;
        mem_en_c_o    = 1'b0;
        mem_we_c_o    = 1'b0;
        mem_addr_c_o  = addr_q;
        mem_wdata_c_o = wdata_q;

        if (fetch) begin
            mem_en_c_o   = 1'b1;
            mem_addr_c_o = fb_addr;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (wr.req && !fetch) begin
                    ack_c      = 1'b1;
                    wr_state_d = W_ACK;
                    if (in_range) begin
                        mem_en_c_o    = 1'b1;
                        mem_we_c_o    = 1'b1;
                        mem_addr_c_o  = wr.addr;
                        mem_wdata_c_o = wr.data;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            W_ACK:   wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase

        if (rst) begin
            ack_c         = 1'b0;
            mem_en_c_o    = 1'b0;
            mem_we_c_o    = 1'b0;
            mem_addr_c_o  = '0;
            mem_wdata_c_o = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= SLOT_LAST;
            wr_state_q <= W_IDLE;
            wr_err_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pix_buf_q  <= '0;
            video_on_q <= 1'b0;
            rgb_q      <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            wr_state_q <= wr_state_d;
            wr_err_q   <= wr_err_d;
            addr_q     <= mem_addr_c_o;
            wdata_q    <= mem_wdata_c_o;
            if (slot_q == SLOT_CAPTURE) begin
                pix_buf_q <= mem_rdata_i;
            end
            if (slot_q == SLOT_FETCH) begin
                video_on_q <= video_on_i;
            end
            if (p_tick_i) begin
                rgb_q   <= video_on_q ? pix_buf_q : '0;
                hsync_q <= hsync_i;
                vsync_q <= vsync_i;
            end
        end
    end

    assign wr.ack_c = ack_c;
    assign wr.err   = wr_err_q;
    assign hsync_o  = hsync_q;
    assign vsync_o  = vsync_q;
    assign rgb_o    = rgb_q;

endmodule
